hack_fetch: RTL and testbench

HACK_FETCH -- requirements
Module: hack_fetch

---
 rtl/hack_fetch_pkg.sv | 14 +
 rtl/hack_fetch_if.sv | 29 ++
 rtl/hack_fetch_timeout.sv | 39 +++
 rtl/hack_fetch.sv | 88 ++++++++
 tb/tb_hack_fetch.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/hack_fetch_pkg.sv
// Shared types and constants for the hack_fetch instruction fetch unit.
// Optional ROM timeout monitor is enabled by defining HACK_FETCH_TIMEOUT_EN.
package hack_fetch_pkg;

    localparam int WORD_W = 16;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/hack_fetch_if.sv
// Fetch-unit bus: PC handshake, ROM read port and decoder-side instruction port.
// master = fetch unit, slave = PC/ROM/decoder environment.
interface hack_fetch_if;
    import hack_fetch_pkg::*;

    logic [WORD_W-1:0] pc_in;
    logic              pc_inc;
    logic              flush;
    logic              rom_req;
    logic [WORD_W-1:0] rom_addr;
    logic              rom_ack;
    logic [WORD_W-1:0] rom_data;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              rom_timeout;

    modport master (
        input  pc_in, flush, rom_ack, rom_data, instr_ready,
        output pc_inc, rom_req, rom_addr, instr, instr_pc, instr_valid, rom_timeout
    );

    modport slave (
        output pc_in, flush, rom_ack, rom_data, instr_ready,
        input  pc_inc, rom_req, rom_addr, instr, instr_pc, instr_valid, rom_timeout
    );

endinterface

// File: rtl/hack_fetch_timeout.sv
// fetch_timeout: saturating wait counter for an outstanding ROM read.
// Sets a sticky flag once the request has waited TIMEOUT_LIMIT cycles; cleared only by reset.
module fetch_timeout
    import hack_fetch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    input  logic ack,
    output logic timeout
);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = 8'd0;
        end else if (busy && !ack && (cnt_q != TIMEOUT_LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end
        timeout_d = timeout_q | (cnt_d == TIMEOUT_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/hack_fetch.sv
// hack_fetch: single-outstanding ROM instruction fetch FSM (IDLE -> REQ -> HOLD).
// Define HACK_FETCH_TIMEOUT_EN to add the sticky rom_timeout monitor.
module hack_fetch
    import hack_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    hack_fetch_if.master bus
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] instr_pc_q, instr_pc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // flush outranks ack/ready; the PC reloads on the flush edge, so re-sample from IDLE
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = REQ;
                    addr_d  = bus.pc_in;
                end
                REQ: begin
                    if (bus.rom_ack) begin
                        instr_d    = bus.rom_data;
                        instr_pc_d = addr_q;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        state_d = REQ;
                        addr_d  = bus.pc_in;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.rom_req     = (state_q == REQ);
    assign bus.rom_addr    = addr_q;
    assign bus.pc_inc      = (state_q == REQ) & bus.rom_ack & ~bus.flush;
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

`ifdef HACK_FETCH_TIMEOUT_EN
    logic to_start;
    logic to_busy;

    assign to_start = (state_d == REQ) && (state_q != REQ);
    assign to_busy  = (state_q == REQ);

    fetch_timeout u_timeout (
        .clk     (clk),
        .reset   (reset),
        .start   (to_start),
        .busy    (to_busy),
        .ack     (bus.rom_ack),
        .timeout (bus.rom_timeout)
    );
`else
    assign bus.rom_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hack_fetch.sv
// Directed scoreboard bench for hack_fetch; bench models the PC (increments on pc_inc).
// Timeout expectations follow HACK_FETCH_TIMEOUT_EN.
module tb_hack_fetch;

    logic clk;
    logic reset;
    int   total;
    int   passed;
    logic [31:0] exp_q[$];
    logic        to_exp;

    hack_fetch_if bus ();

    hack_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // one clock; PC follows pc_inc sampled just before the edge
    task automatic tick();
        logic inc;
        #1;
        inc = bus.pc_inc;
        @(posedge clk);
        #1;
        if (inc === 1'b1) bus.pc_in = bus.pc_in + 16'd1;
    endtask

    task automatic push_exp(input logic [15:0] data, input logic [15:0] addr);
        exp_q.push_back({data, addr});
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        for (int i = 0; i < 8 && bus.instr_valid !== 1'b1; i++) tick();
        chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk({tag, "_instr"}, {bus.instr, bus.instr_pc}, e);
    endtask

    initial begin
        total  = 0;
        passed = 0;
`ifdef HACK_FETCH_TIMEOUT_EN
        to_exp = 1'b1;
`else
        to_exp = 1'b0;
`endif
        reset           = 1'b1;
        bus.pc_in       = 16'h0000;
        bus.flush       = 1'b0;
        bus.rom_ack     = 1'b1;
        bus.rom_data    = 16'hFFFF;
        bus.instr_ready = 1'b1;
        repeat (3) tick();
        chk("rst_rom_req", {31'd0, bus.rom_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
        chk("rst_instr", {16'd0, bus.instr}, 32'd0);
        chk("rst_instr_pc", {16'd0, bus.instr_pc}, 32'd0);
        chk("rst_timeout", {31'd0, bus.rom_timeout}, 32'd0);

        // first fetch, zero-wait ROM
        bus.rom_ack = 1'b0;
        reset = 1'b0;
        #1;
        chk("first_idle_req", {31'd0, bus.rom_req}, 32'd0);
        tick();
        chk("first_rom_req", {31'd0, bus.rom_req}, 32'd1);
        chk("first_rom_addr", {16'd0, bus.rom_addr}, 32'h0000);
        bus.rom_ack = 1'b1; bus.rom_data = 16'h1234; bus.instr_ready = 1'b1;
        #1;
        chk("first_pc_inc", {31'd0, bus.pc_inc}, 32'd1);
        push_exp(16'h1234, 16'h0000);
        tick();
        bus.rom_ack = 1'b0;
        pop_check("first");
        tick();
        chk("thru_rom_req", {31'd0, bus.rom_req}, 32'd1);
        chk("thru_rom_addr", {16'd0, bus.rom_addr}, 32'h0001);

        // flush to 5, then ack delayed 3 cycles
        bus.flush = 1'b1;
        #1;
        chk("flush1_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
        tick();
        bus.flush = 1'b0; bus.pc_in = 16'h0005;
        #1;
        chk("flush1_rom_req", {31'd0, bus.rom_req}, 32'd0);
        chk("flush1_valid", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wait_rom_req", {31'd0, bus.rom_req}, 32'd1);
            chk("wait_rom_addr", {16'd0, bus.rom_addr}, 32'h0005);
            chk("wait_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
            tick();
        end
        bus.rom_ack = 1'b1; bus.rom_data = 16'hABCD; bus.instr_ready = 1'b0;
        #1;
        chk("late_pc_inc", {31'd0, bus.pc_inc}, 32'd1);
        push_exp(16'hABCD, 16'h0005);
        tick();
        bus.rom_data = 16'hDEAD;
        pop_check("late");

        // HOLD stall, stray ack must be ignored
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("stall_instr", {bus.instr, bus.instr_pc}, {16'hABCD, 16'h0005});
            chk("stall_rom_req", {31'd0, bus.rom_req}, 32'd0);
            chk("stall_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
            tick();
        end
        bus.rom_ack = 1'b0; bus.instr_ready = 1'b1;
        tick();
        chk("resume_rom_addr", {16'd0, bus.rom_addr}, 32'h0006);
        chk("resume_valid", {31'd0, bus.instr_valid}, 32'd0);

        // flush and ack in the same cycle
        bus.flush = 1'b1; bus.rom_ack = 1'b1; bus.rom_data = 16'hBAD0;
        #1;
        chk("flush_ack_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
        tick();
        bus.flush = 1'b0; bus.rom_ack = 1'b0; bus.pc_in = 16'h2222;
        #1;
        chk("flush_ack_rom_req", {31'd0, bus.rom_req}, 32'd0);
        chk("flush_ack_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("flush_ack_instr", {16'd0, bus.instr}, 32'h0000_ABCD);
        tick();
        chk("reload_rom_req", {31'd0, bus.rom_req}, 32'd1);
        chk("reload_rom_addr", {16'd0, bus.rom_addr}, 32'h2222);

        // PC wrap 0xFFFF -> 0x0000
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.pc_in = 16'hFFFF;
        tick();
        chk("wrap_rom_addr_hi", {16'd0, bus.rom_addr}, 32'hFFFF);
        bus.rom_ack = 1'b1; bus.rom_data = 16'h5555; bus.instr_ready = 1'b1;
        push_exp(16'h5555, 16'hFFFF);
        tick();
        bus.rom_ack = 1'b0;
        pop_check("wrap_hi");
        tick();
        chk("wrap_rom_addr_lo", {16'd0, bus.rom_addr}, 32'h0000);
        bus.rom_ack = 1'b1; bus.rom_data = 16'h6666;
        push_exp(16'h6666, 16'h0000);
        tick();
        bus.rom_ack = 1'b0; bus.instr_ready = 1'b0;
        pop_check("wrap_lo");
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;

        // ROM never answers for 255 cycles
        repeat (254) tick();
        chk("to_before", {31'd0, bus.rom_timeout}, 32'd0);
        tick();
        chk("to_at_limit", {31'd0, bus.rom_timeout}, {31'd0, to_exp});
        chk("to_rom_req", {31'd0, bus.rom_req}, 32'd1);
        chk("to_rom_addr", {16'd0, bus.rom_addr}, 32'h0001);
        bus.rom_ack = 1'b1; bus.rom_data = 16'h7777;
        push_exp(16'h7777, 16'h0001);
        tick();
        bus.rom_ack = 1'b0;
        pop_check("to_late");
        chk("to_sticky_hold", {31'd0, bus.rom_timeout}, {31'd0, to_exp});
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        tick();
        chk("to_sticky_req", {31'd0, bus.rom_timeout}, {31'd0, to_exp});

        // reset mid-REQ with an ack pending
        bus.rom_ack = 1'b1; bus.rom_data = 16'h9999;
        reset = 1'b1;
        #1;
        chk("rstreq_rom_req", {31'd0, bus.rom_req}, 32'd0);
        chk("rstreq_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
        chk("rstreq_timeout", {31'd0, bus.rom_timeout}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("post_rst_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
        chk("post_rst_instr", {bus.instr, bus.instr_pc}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
